// File: rtl/oamdma.sv
// Sprite DMA engine behind $4014: copies CPU page $PP00..$PPFF into OAM by
// reading each byte on the CPU bus and writing it to the PPU OAMDATA register.
module oamdma #(
  parameter logic [2:0] OAMDATA_ADDR = 3'd4,
  parameter bit         ALIGN_ODD    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        wr4014,
  input  logic [7:0]  wdata,
  output logic        cpustall,
  output logic        busy,
  output logic [15:0] dmaaddr,
  output logic        dmareq,
  input  logic        dmaack,
  input  logic [7:0]  dmardata,
  output logic [2:0]  ppuaddr,
  output logic [7:0]  ppuwdata,
  output logic        ppuwr,
  output logic        ppureq,
  input  logic        ppuack
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t     state, state_nx;
  logic [7:0] page, idx, latch;
  logic       odd, done;
  logic       dmareq_q, ppureq_q;
  logic       advance;

  // A transfer state only moves on once its handshake has completed.
  assign advance = tick && done && (state == READ || state == WRITE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      IDLE:    if (wr4014) state_nx = HALT;
      HALT:    if (tick) state_nx = (ALIGN_ODD && odd) ? ALIGN : READ;
      ALIGN:   if (tick) state_nx = READ;
      READ:    if (advance) state_nx = WRITE;
      WRITE:   if (advance) state_nx = (idx == 8'hFF) ? IDLE : READ;
      default: state_nx = IDLE;
    endcase
  end

  // Requests are registered so a reset clears them asynchronously, and are
  // only raised once the previous transfer's ack has fallen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      page     <= 8'd0;
      idx      <= 8'd0;
      latch    <= 8'd0;
      odd      <= 1'b0;
      done     <= 1'b0;
      dmareq_q <= 1'b0;
      ppureq_q <= 1'b0;
    end else begin
      if (tick) odd <= ~odd;
      if (advance) done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr4014) begin
            page <= wdata;
            idx  <= 8'd0;
          end
        end
        READ: begin
          if (!done && !dmareq_q && !dmaack) dmareq_q <= 1'b1;
          if (dmareq_q && dmaack) begin
            latch    <= dmardata;
            dmareq_q <= 1'b0;
            done     <= 1'b1;
          end
        end
        WRITE: begin
          if (!done && !ppureq_q && !ppuack) ppureq_q <= 1'b1;
          if (ppureq_q && ppuack) begin
            ppureq_q <= 1'b0;
            done     <= 1'b1;
          end
          if (advance && idx != 8'hFF) idx <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign cpustall = busy;
  assign dmaaddr  = {page, idx};
  assign dmareq   = dmareq_q;
  assign ppureq   = ppureq_q;
  assign ppuwr    = ppureq_q;
  assign ppuaddr  = OAMDATA_ADDR;
  assign ppuwdata = latch;

endmodule

// File: tb/tb_oamdma.sv
// Scoreboard bench for oamdma: stimulus queues expected reads/writes, a
// negedge responder acts as CPU bus and PPU, popping and checking each request.
module tb_oamdma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        wr4014 = 1'b0;
  logic [7:0]  wdata = 8'd0;
  logic        cpustall, busy, dmareq, ppuwr, ppureq;
  logic [15:0] dmaaddr;
  logic [2:0]  ppuaddr;
  logic [7:0]  ppuwdata;
  logic        dmaack = 1'b0;
  logic        ppuack = 1'b0;
  logic [7:0]  dmardata = 8'd0;

  oamdma dut (
    .clk(clk), .reset(reset), .tick(tick), .wr4014(wr4014), .wdata(wdata),
    .cpustall(cpustall), .busy(busy), .dmaaddr(dmaaddr), .dmareq(dmareq),
    .dmaack(dmaack), .dmardata(dmardata), .ppuaddr(ppuaddr), .ppuwdata(ppuwdata),
    .ppuwr(ppuwr), .ppureq(ppureq), .ppuack(ppuack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: memory image, expected transfer order, per-byte ack delays.
  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];
  int rd_dly [256];
  int wr_dly [256];

  int n_rd = 0, n_wr = 0, rd_base = 0, wr_base = 0;
  int stall_ticks = 0, stall_base = 0, ticks_total = 0;
  int first_req_ticks = -1;
  int exp_cycles = 0, exp_align = 0;
  int phase = 0, rd_wait = 0, wr_wait = 0;
  logic rd_busy = 1'b0, wr_busy = 1'b0;
  logic [15:0] rd_exp = 16'd0;
  logic [7:0]  wr_exp = 8'd0;

  // Bus/PPU responder and CPU-cycle generator, one negedge process.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        dmaack = 1'b0; ppuack = 1'b0; rd_busy = 1'b0; wr_busy = 1'b0;
        tick = 1'b0; ticks_total = 0; phase = 0;
      end else begin
        if (!dmareq) dmaack = 1'b0;
        else if (!dmaack) begin
          if (!rd_busy) begin
            if (rd_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL rd_unexpected: read of %0h with nothing expected", dmaaddr);
            end else begin
              rd_exp = rd_q.pop_front();
              check("rd_addr", {16'd0, dmaaddr}, {16'd0, rd_exp});
              if (n_rd == rd_base) first_req_ticks = stall_ticks - stall_base;
              rd_wait = 4 * rd_dly[(n_rd - rd_base) & 255];
              n_rd++;
              rd_busy = 1'b1;
            end
          end
          if (rd_busy) begin
            if (rd_wait == 0) begin
              check("rd_addr_hold", {16'd0, dmaaddr}, {16'd0, rd_exp});
              dmardata = mem[rd_exp];
              dmaack = 1'b1;
              rd_busy = 1'b0;
            end else rd_wait--;
          end
        end

        if (!ppureq) ppuack = 1'b0;
        else if (!ppuack) begin
          if (!wr_busy) begin
            if (wr_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL wr_unexpected: ppu write of %0h with nothing expected", ppuwdata);
            end else begin
              wr_exp = wr_q.pop_front();
              check("ppu_data", {24'd0, ppuwdata}, {24'd0, wr_exp});
              check("ppu_addr", {29'd0, ppuaddr}, 32'd4);
              check("ppu_wr", {31'd0, ppuwr}, 32'd1);
              wr_wait = 4 * wr_dly[(n_wr - wr_base) & 255];
              n_wr++;
              wr_busy = 1'b1;
            end
          end
          if (wr_busy) begin
            if (wr_wait == 0) begin
              check("ppu_data_hold", {24'd0, ppuwdata}, {24'd0, wr_exp});
              ppuack = 1'b1;
              wr_busy = 1'b0;
            end else wr_wait--;
          end
        end

        phase = (phase + 1) % 4;
        tick = (phase == 0);
        if (tick) begin
          ticks_total++;
          if (cpustall) stall_ticks++;
        end
      end
    end
  end

  task automatic clear_delays();
    for (int i = 0; i < 256; i++) begin
      rd_dly[i] = 0;
      wr_dly[i] = 0;
    end
  endtask

  // par: required CPU-cycle parity at start (0/1), or -1 for whatever comes.
  task automatic issue(input logic [7:0] p, input int par);
    int extra;
    extra = 0;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {p, 8'(i)};
      rd_q.push_back(a);
      wr_q.push_back(mem[a]);
      extra += rd_dly[i] + wr_dly[i];
    end
    forever begin
      @(negedge clk);
      #1;
      if (par < 0 || (ticks_total % 2) == par) break;
    end
    exp_align  = ticks_total % 2;
    exp_cycles = 1 + exp_align + 512 + extra;
    stall_base = stall_ticks;
    rd_base = n_rd;
    wr_base = n_wr;
    first_req_ticks = -1;
    wr4014 = 1'b1;
    wdata  = p;
    @(negedge clk);
    #1;
    wr4014 = 1'b0;
    check("busy_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_end();
    for (int c = 0; c < 20000 && busy; c++) @(negedge clk);
    #1;
    check("dma_done", {31'd0, busy}, 32'd0);
    check("stall_end", {31'd0, cpustall}, 32'd0);
    check("stall_cycles", stall_ticks - stall_base, exp_cycles);
    check("first_req_tick", first_req_ticks, 1 + exp_align);
    check("reads_left", rd_q.size(), 32'd0);
    check("writes_left", wr_q.size(), 32'd0);
    check("dmareq_idle", {31'd0, dmareq}, 32'd0);
    check("ppureq_idle", {31'd0, ppureq}, 32'd0);
  endtask

  task automatic wait_reads(input int n);
    for (int c = 0; c < 20000 && (n_rd - rd_base) < n; c++) @(negedge clk);
    #1;
  endtask

  task automatic wait_writes(input int n);
    for (int c = 0; c < 20000 && (n_wr - wr_base) < n; c++) @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    clear_delays();

    repeat (3) @(negedge clk);
    #1;
    check("rst_cpustall", {31'd0, cpustall}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dmaaddr", {16'd0, dmaaddr}, 32'd0);
    check("rst_dmareq", {31'd0, dmareq}, 32'd0);
    check("rst_ppureq", {31'd0, ppureq}, 32'd0);
    check("rst_ppuwr", {31'd0, ppuwr}, 32'd0);
    check("rst_ppuwdata", {24'd0, ppuwdata}, 32'd0);
    check("rst_ppuaddr", {29'd0, ppuaddr}, 32'd4);
    reset = 1'b0;

    // Even and odd starts.
    issue(8'h02, 0);
    wait_end();
    issue(8'h02, 1);
    wait_end();

    // Slow acks on read byte 5 and write byte 9.
    rd_dly[5] = 3;
    wr_dly[9] = 2;
    issue(8'h02, 0);
    wait_end();
    clear_delays();

    // Second $4014 write mid-transfer is ignored.
    issue(8'h02, -1);
    wait_reads(41);
    wr4014 = 1'b1;
    wdata  = 8'h07;
    @(negedge clk);
    #1;
    wr4014 = 1'b0;
    wait_end();

    // Reset while writing byte 100, then restart from idx 0.
    issue(8'h03, -1);
    wait_writes(101);
    check("pre_reset_ppureq", {31'd0, ppureq}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_ppureq", {31'd0, ppureq}, 32'd0);
    check("reset_dmareq", {31'd0, dmareq}, 32'd0);
    check("reset_cpustall", {31'd0, cpustall}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rd_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    issue(8'h05, -1);
    wait_end();

    // Top page: last address is $FFFF.
    issue(8'hFF, -1);
    wait_end();
    check("last_addr", {16'd0, dmaaddr}, 32'h0000FFFF);

    // Randomized pages, parities and ack delays.
    for (int t = 0; t < 4; t++) begin
      clear_delays();
      for (int k = 0; k < 3; k++) begin
        rd_dly[$urandom_range(0, 255)] = $urandom_range(0, 2);
        wr_dly[$urandom_range(0, 255)] = $urandom_range(0, 2);
      end
      issue(8'($urandom), $urandom_range(0, 1));
      wait_end();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
